// File: rtl/scan_pkg.sv
// Shared types and constants for the channel-scan sequencer.
// Optional blanking between channels is enabled with `define SCAN_BLANK_EN.
package scan_pkg;
    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_BLANK
    } scan_state_t;

    localparam logic [7:0] CODE_IDLE_DEF = 8'hFF;
    localparam int MAX_CHANNELS = 8;
endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between a scan controller and the sequencer.
// Blanking (SCAN_BLANK_EN) does not change this interface.
interface scan_sequencer_if #(
    parameter int N = 8
);
    logic         start;
    logic         stop;
    logic         loop;
    logic [N-1:0] code;
    logic         code_valid;
    logic         chan_strobe;
    logic         busy;
    logic         done;

    modport master (
        output start, stop, loop,
        input  code, code_valid, chan_strobe, busy, done
    );

    modport slave (
        input  start, stop, loop,
        output code, code_valid, chan_strobe, busy, done
    );
endinterface

// File: rtl/scan_sequencer_dwell_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Shared by dwell and blanking phases (SCAN_BLANK_EN).
module dwell_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/scan_sequencer.sv
// Timed channel-scan sequencer driving a one-hot decoder's code input.
// `define SCAN_BLANK_EN inserts BLANK idle-code gaps between channels.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int           N         = 8,
    parameter int           CHANNELS  = 8,
    parameter int           DWELL     = 1000,
    parameter int           BLANK     = 16,
    parameter logic [N-1:0] CODE_IDLE = N'(CODE_IDLE_DEF)
) (
    input logic             clk,
    input logic             reset,
    scan_sequencer_if.slave bus
);
    localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] DW_LD = TW'(DWELL - 1);
`ifdef SCAN_BLANK_EN
    localparam logic [TW-1:0] BL_LD = TW'(BLANK - 1);
`endif

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("scan_sequencer: CHANNELS out of range");
    end

    scan_state_t   state;
    logic [CW-1:0] ch;
    logic [CW-1:0] ch_nxt;
    logic          loop_q;
    logic          last;
    logic          ld;
    logic [TW-1:0] ld_val;
    logic          tc;
    logic [N-1:0]  code_q;
    logic          valid_q;
    logic          strobe_q;
    logic          busy_q;
    logic          done_q;

    always_comb begin
        last   = (ch == CW'(CHANNELS - 1));
        ch_nxt = last ? '0 : ch + CW'(1);
        ld     = 1'b0;
        ld_val = DW_LD;
        case (state)
            S_IDLE:  ld = bus.start && !bus.stop;
            S_DWELL: begin
                ld = tc;
`ifdef SCAN_BLANK_EN
                ld_val = BL_LD;
`endif
            end
            S_BLANK: ld = tc;
            default: ld = 1'b0;
        endcase
    end

    dwell_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .load_val (ld_val),
        .tc       (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            ch       <= '0;
            loop_q   <= 1'b0;
            code_q   <= CODE_IDLE;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            // Abort beats every other transition, including completion.
            if (state != S_IDLE && bus.stop) begin
                state   <= S_IDLE;
                ch      <= '0;
                loop_q  <= 1'b0;
                code_q  <= CODE_IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start && !bus.stop) begin
                            state    <= S_DWELL;
                            ch       <= '0;
                            loop_q   <= bus.loop;
                            code_q   <= '0;
                            valid_q  <= 1'b1;
                            strobe_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                    S_DWELL: begin
                        if (tc) begin
                            if (last && !loop_q) begin
                                state   <= S_IDLE;
                                ch      <= '0;
                                code_q  <= CODE_IDLE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                ch <= ch_nxt;
`ifdef SCAN_BLANK_EN
                                state   <= S_BLANK;
                                code_q  <= CODE_IDLE;
                                valid_q <= 1'b0;
`else
                                code_q   <= N'(ch_nxt);
                                strobe_q <= 1'b1;
`endif
                            end
                        end
                    end
                    S_BLANK: begin
                        if (tc) begin
                            state    <= S_DWELL;
                            code_q   <= N'(ch);
                            valid_q  <= 1'b1;
                            strobe_q <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.code        = code_q;
    assign bus.code_valid  = valid_q;
    assign bus.chan_strobe = strobe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench: timeline reference model feeds queues, monitor compares.
// Two DUTs: 8 ch / dwell 4 / blank 2, and 1 ch / dwell 1 / blank 1.
module tb_scan_sequencer;
    typedef struct packed {
        logic [7:0] code;
        logic       v;
        logic       s;
        logic       b;
        logic       d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scan_sequencer_if #(.N(8)) b0 ();
    scan_sequencer_if #(.N(8)) b1 ();

    scan_sequencer #(
        .N(8), .CHANNELS(8), .DWELL(4), .BLANK(2), .CODE_IDLE(8'hFF)
    ) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    scan_sequencer #(
        .N(8), .CHANNELS(1), .DWELL(1), .BLANK(1), .CODE_IDLE(8'hFF)
    ) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    int chn [2] = '{8, 1};
    int dwl [2] = '{4, 1};
`ifdef SCAN_BLANK_EN
    int blk [2] = '{2, 1};
`else
    int blk [2] = '{0, 0};
`endif

    bit   act [2];
    int   pos [2];
    bit   lpm [2];
    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t idle_e();
        exp_t e;
        e.code = 8'hFF;
        e.v = 0; e.s = 0; e.b = 0; e.d = 0;
        return e;
    endfunction

    // Position in the scan timeline -> expected outputs.
    function automatic exp_t calc(int id);
        exp_t e;
        int per;
        int k;
        int q;
        per = dwl[id] + blk[id];
        k = pos[id] / per;
        q = pos[id] % per;
        if (lpm[id]) k = k % chn[id];
        e = idle_e();
        e.b = 1;
        if (q < dwl[id]) begin
            e.code = 8'(k);
            e.v = 1;
            e.s = (q == 0);
        end
        return e;
    endfunction

    function automatic exp_t step(int id, bit r, bit s, bit p, bit l);
        exp_t e;
        int total;
        total = chn[id] * dwl[id] + (chn[id] - 1) * blk[id];
        e = idle_e();
        if (r) begin
            act[id] = 0;
        end else if (act[id] && p) begin
            act[id] = 0;
        end else if (!act[id]) begin
            if (s && !p) begin
                act[id] = 1;
                pos[id] = 0;
                lpm[id] = l;
                e = calc(id);
            end
        end else begin
            pos[id]++;
            if (!lpm[id] && pos[id] == total) begin
                act[id] = 0;
                e.d = 1;
            end else begin
                e = calc(id);
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        q0.push_back(step(0, reset, b0.start, b0.stop, b0.loop));
        q1.push_back(step(1, reset, b1.start, b1.stop, b1.loop));
        @(negedge clk);
    endtask

    task automatic set0(input bit s, input bit p, input bit l);
        b0.start = s; b0.stop = p; b0.loop = l;
    endtask

    task automatic set1(input bit s, input bit p, input bit l);
        b1.start = s; b1.stop = p; b1.loop = l;
    endtask

    function automatic exp_t got0();
        return {b0.code, b0.code_valid, b0.chan_strobe, b0.busy, b0.done};
    endfunction

    function automatic exp_t got1();
        return {b1.code, b1.code_valid, b1.chan_strobe, b1.busy, b1.done};
    endfunction

    task automatic chk(input string nm, input exp_t g, input exp_t e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s t=%0t got code=%h v=%b s=%b b=%b d=%b want code=%h v=%b s=%b b=%b d=%b",
                     nm, $time, g.code, g.v, g.s, g.b, g.d,
                     e.code, e.v, e.s, e.b, e.d);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) chk("dut0", got0(), q0.pop_front());
        if (q1.size() > 0) chk("dut1", got1(), q1.pop_front());
    end

    initial begin
        reset = 1'b1;
        set0(0, 0, 0);
        set1(0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // single-shot full scan
        set0(1, 0, 0); tick(); set0(0, 0, 0);
        repeat (52) tick();

        // loop: three passes, then stop
        set0(1, 0, 1); tick(); set0(0, 0, 0);
        repeat (150) tick();
        set0(0, 1, 0); tick(); set0(0, 0, 0);
        repeat (3) tick();

        // start with stop in idle
        set0(1, 1, 0); tick(); set0(0, 0, 0);
        repeat (3) tick();

        // start mid-scan with loop=1 is ignored
        set0(1, 0, 0); tick(); set0(0, 0, 0);
        repeat (10) tick();
        set0(1, 0, 1); tick(); set0(0, 0, 0);
        repeat (45) tick();

        // async reset during channel 3 dwell
        set0(1, 0, 0); tick(); set0(0, 0, 0);
        repeat (3 * (dwl[0] + blk[0]) + 1) tick();
        #2 reset = 1'b1;
        #1;
        chk("async_reset0", got0(), idle_e());
        chk("async_reset1", got1(), idle_e());
        tick();
        reset = 1'b0;
        repeat (2) tick();
        set0(1, 0, 0); tick(); set0(0, 0, 0);
        repeat (5) tick();
        set0(0, 1, 0); tick(); set0(0, 0, 0);
        tick();

        // single channel, dwell 1
        set1(1, 0, 0); tick(); set1(0, 0, 0);
        repeat (3) tick();
        set1(1, 0, 1); tick(); set1(0, 0, 0);
        repeat (6) tick();
        set1(0, 1, 0); tick(); set1(0, 0, 0);
        tick();

        repeat (2000) begin
            set0($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                 1'($urandom_range(0, 1)));
            set1($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 1'($urandom_range(0, 1)));
            tick();
        end
        set0(0, 0, 0);
        set1(0, 0, 0);
        tick();
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
